// File: rtl/da_output_collector_pkg.sv
// Shared helpers for the distributed-arithmetic output path: width helper and
// the rounding / ReLU / saturation post-process applied to every captured element.
package da_cnn_pkg;

  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  // $clog2 that never returns 0, so single-entry indices still get one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Round-half-up arithmetic right shift, optional ReLU, then clamp to a
  // signed out_w-bit range. Works in a wide signed domain so the rounding
  // add can never wrap.
  function automatic calc_t sat_round(input calc_t value, input int shift,
                                      input logic relu, input int out_w);
    calc_t v;
    calc_t hi;
    calc_t lo;
    v = value;
    if (shift > 0) begin
      v = v + (calc_t'(1) <<< (shift - 1));
    end
    v = v >>> shift;
    if (relu && v[CALC_W-1]) begin
      v = '0;
    end
    hi = (calc_t'(1) <<< (out_w - 1)) - calc_t'(1);
    lo = -(calc_t'(1) <<< (out_w - 1));
    if (v > hi) begin
      v = hi;
    end else if (v < lo) begin
      v = lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/da_output_collector_if.sv
// Row stream from the output collector to the next layer.
//
// Handshake: a row transfers on every rising clk edge where out_valid and
// out_ready are both high. Once out_valid is high it stays high, and
// out_data/out_row/out_last stay stable, until that transfer happens;
// out_valid never depends combinationally on out_ready.
interface da_output_collector_if #(
  parameter int N         = 1,
  parameter int OUT_WIDTH = 8,
  parameter int ROW_W     = 1
);
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data [N];
  logic [ROW_W-1:0]            out_row;
  logic                        out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_row,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/da_output_collector_pingpong.sv
// Double-buffered M x N tile store: one bank fills from captures while the
// other drains row by row; full flags arbitrate ownership of each bank.
module da_tile_pingpong
  import da_cnn_pkg::*;
#(
  parameter int M     = 1,
  parameter int N     = 1,
  parameter int W     = 8,
  parameter int ROW_W = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ROW_W-1:0]    wr_row,
  input  logic signed [W-1:0] wr_data [N],
  output logic                dropped,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic signed [W-1:0] rd_data [N],
  output logic [ROW_W-1:0]    rd_row,
  output logic                rd_last
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(M - 1);

  logic signed [W-1:0] mem [2][M][N];
  logic [1:0]          full;
  logic [1:0]          full_n;
  logic                wb;
  logic                rb;
  logic [ROW_W-1:0]    drow;
  logic                fire;
  logic                release_rb;
  logic                accept;
  logic                wr_last;

  assign fire       = full[rb] && rd_ready;
  assign release_rb = fire && (drow == ROW_LAST);
  // A full write bank may still be reused when the drain frees it this cycle.
  assign accept     = wr_en && (!full[wb] || (release_rb && (rb == wb)));
  assign dropped    = wr_en && !accept;
  assign wr_last    = accept && (wr_row == ROW_LAST);

  // Clear-on-release first so a same-cycle tile completion re-marks the bank.
  always_comb begin
    full_n = full;
    if (release_rb) begin
      full_n[rb] = 1'b0;
    end
    if (wr_last) begin
      full_n[wb] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
      wb   <= 1'b0;
      rb   <= 1'b0;
      drow <= '0;
    end else begin
      full <= full_n;
      if (wr_last) begin
        wb <= ~wb;
      end
      if (fire) begin
        if (drow == ROW_LAST) begin
          drow <= '0;
          rb   <= ~rb;
        end else begin
          drow <= drow + ROW_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < N; c++) begin
        mem[wb][wr_row][c] <= wr_data[c];
      end
    end
  end

  assign rd_valid = full[rb];
  assign rd_row   = drow;
  assign rd_last  = full[rb] && (drow == ROW_LAST);

  always_comb begin
    for (int c = 0; c < N; c++) begin
      rd_data[c] = full[rb] ? mem[rb][drow][c] : '0;
    end
  end

endmodule

// File: rtl/da_output_collector.sv
// Output collector for the bit-serial DA array: tracks bit phase and row from
// gen_done, post-processes each completed row and hands it to the tile store.
module da_output_collector
  import da_cnn_pkg::*;
#(
  parameter int DATA_WIDTH_A      = 8,
  parameter int DATA_WIDTH_output = 8,
  parameter int OUT_WIDTH         = 8,
  parameter int M                 = 1,
  parameter int N                 = 1,
  parameter int SHIFT             = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                gen_done,
  input  logic                                relu_en,
  input  logic signed [DATA_WIDTH_output-1:0] final_out [N],
  da_output_collector_if.master               out_if,
  output logic                                overflow
);

  localparam int ROW_W = clog2_min1(M);
  localparam int PH_W  = clog2_min1(DATA_WIDTH_A);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DATA_WIDTH_A - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(M - 1);

  logic [PH_W-1:0]             ph;
  logic [ROW_W-1:0]            r;
  logic                        primed;
  logic                        cap;
  logic [ROW_W-1:0]            cap_row;
  logic                        dropped;
  calc_t                       wide;
  logic signed [OUT_WIDTH-1:0] proc [N];

  // The row finishes when ph wraps, so final_out is valid at the next ph==0
  // and belongs to the row before r. primed masks the very first wrap.
  assign cap     = gen_done && (ph == '0) && primed;
  assign cap_row = (r == '0) ? ROW_LAST : r - ROW_W'(1);

  always_comb begin
    wide = '0;
    for (int c = 0; c < N; c++) begin
      wide    = calc_t'(final_out[c]);
      wide    = sat_round(wide, SHIFT, relu_en, OUT_WIDTH);
      proc[c] = wide[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph       <= '0;
      r        <= '0;
      primed   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (gen_done) begin
        if (ph == PH_LAST) begin
          ph     <= '0;
          r      <= (r == ROW_LAST) ? '0 : r + ROW_W'(1);
          primed <= 1'b1;
        end else begin
          ph <= ph + PH_W'(1);
        end
      end
      if (dropped) begin
        overflow <= 1'b1;
      end
    end
  end

  da_tile_pingpong #(
    .M     (M),
    .N     (N),
    .W     (OUT_WIDTH),
    .ROW_W (ROW_W)
  ) u_tiles (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (cap),
    .wr_row   (cap_row),
    .wr_data  (proc),
    .dropped  (dropped),
    .rd_valid (out_if.out_valid),
    .rd_ready (out_if.out_ready),
    .rd_data  (out_if.out_data),
    .rd_row   (out_if.out_row),
    .rd_last  (out_if.out_last)
  );

endmodule
